alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Alarm-clock controller: alarm time entry (hours/minutes, BCD), arming,
// time-match ringing with auto-stop, snooze, and FND display/blink drive.
// Every output is a register. Next-state values feed the output registers
// so that a button or tick response shows up one cycle after the strobe.
module alarm_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       SEC_TICK,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  input  logic       BTN_OK,
  input  logic [3:0] T_H10,
  input  logic [3:0] T_H1,
  input  logic [3:0] T_M10,
  input  logic [3:0] T_M1,
  input  logic       T_SEC_ZERO,
  output logic [3:0] A_H10,
  output logic [3:0] A_H1,
  output logic [3:0] A_M10,
  output logic [3:0] A_M1,
  output logic [3:0] D_H10,
  output logic [3:0] D_H1,
  output logic [3:0] D_M10,
  output logic [3:0] D_M1,
  output logic       FND_EN,
  output logic       BUZZER,
  output logic       ARMED,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SET_H   = 3'd1,
    S_SET_M   = 3'd2,
    S_ARMED   = 3'd3,
    S_RINGING = 3'd4,
    S_SNOOZE  = 3'd5
  } state_t;

  localparam logic [7:0] RING_LIM = 8'(RING_SEC);
  localparam logic [9:0] SNZ_LOAD = 10'(SNOOZE_SEC);
  localparam logic [3:0] BLANK    = 4'hF;

  state_t     state_q, state_d;
  logic [3:0] a_h10_q, a_h1_q, a_m10_q, a_m1_q;
  logic [3:0] a_h10_d, a_h1_d, a_m10_d, a_m1_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic [9:0] snz_cnt_q, snz_cnt_d;
  logic       phase_q, phase_d;
  logic [3:0] d_h10_q, d_h1_q, d_m10_q, d_m1_q;
  logic [3:0] d_h10_d, d_h1_d, d_m10_d, d_m1_d;
  logic       fnd_en_q, fnd_en_d;
  logic       buzzer_q, buzzer_d;
  logic       armed_q, armed_d;

  logic       ok_w, mode_w, up_w, any_btn_w, match_w;
  logic [7:0] hr_nx, mn_nx;

  // BCD hour increment, wrapping 23 -> 00.
  function automatic logic [7:0] inc_hour(input logic [3:0] h10, input logic [3:0] h1);
    logic [7:0] r;
    if (h10 == 4'd2 && h1 == 4'd3) r = 8'h00;
    else if (h1 == 4'd9)           r = {h10 + 4'd1, 4'd0};
    else                           r = {h10, h1 + 4'd1};
    return r;
  endfunction

  // BCD minute increment, wrapping 59 -> 00 without touching the hour.
  function automatic logic [7:0] inc_min(input logic [3:0] m10, input logic [3:0] m1);
    logic [7:0] r;
    if (m1 == 4'd9) r = (m10 == 4'd5) ? 8'h00 : {m10 + 4'd1, 4'd0};
    else            r = {m10, m1 + 4'd1};
    return r;
  endfunction

  // Button arbitration (OK beats MODE beats UP) and time-match detection.
  always_comb begin
    ok_w      = BTN_OK;
    mode_w    = BTN_MODE & ~BTN_OK;
    up_w      = BTN_UP & ~BTN_OK & ~BTN_MODE;
    any_btn_w = BTN_OK | BTN_MODE | BTN_UP;
    match_w   = SEC_TICK & T_SEC_ZERO &
                (T_H10 == a_h10_q) & (T_H1 == a_h1_q) &
                (T_M10 == a_m10_q) & (T_M1 == a_m1_q);
    hr_nx     = inc_hour(a_h10_q, a_h1_q);
    mn_nx     = inc_min(a_m10_q, a_m1_q);
  end

  // Next-state, alarm digits, ring/snooze counters and blink phase.
  always_comb begin
    state_d    = state_q;
    a_h10_d    = a_h10_q;
    a_h1_d     = a_h1_q;
    a_m10_d    = a_m10_q;
    a_m1_d     = a_m1_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    phase_d    = phase_q;
    case (state_q)
      S_IDLE: begin
        if (ok_w)        state_d = S_ARMED;
        else if (mode_w) state_d = S_SET_H;
      end
      S_SET_H: begin
        if (ok_w)        state_d = S_ARMED;
        else if (mode_w) state_d = S_SET_M;
        else if (up_w)   {a_h10_d, a_h1_d} = hr_nx;
      end
      S_SET_M: begin
        if (ok_w)        state_d = S_ARMED;
        else if (mode_w) state_d = S_SET_H;
        else if (up_w)   {a_m10_d, a_m1_d} = mn_nx;
      end
      S_ARMED: begin
        // Any button pulse masks a coincident match.
        if (ok_w)                       state_d = S_IDLE;
        else if (mode_w)                state_d = S_SET_H;
        else if (!any_btn_w && match_w) state_d = S_RINGING;
      end
      S_RINGING: begin
        // MODE is ignored here, so a MODE-only cycle still counts the tick.
        if (ok_w) begin
          state_d = S_ARMED;
        end else if (up_w) begin
          state_d   = S_SNOOZE;
          snz_cnt_d = SNZ_LOAD;
        end else if (SEC_TICK) begin
          ring_cnt_d = ring_cnt_q + 8'd1;
          if (ring_cnt_q + 8'd1 == RING_LIM) state_d = S_ARMED;
        end
      end
      S_SNOOZE: begin
        if (ok_w) begin
          state_d = S_ARMED;
        end else if (SEC_TICK) begin
          snz_cnt_d = snz_cnt_q - 10'd1;
          if (snz_cnt_q == 10'd1) state_d = S_RINGING;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_RINGING && state_q != S_RINGING) ring_cnt_d = '0;

    // Entering a displaying state forces the digits visible; otherwise blink.
    if (state_d != state_q &&
        (state_d == S_SET_H || state_d == S_SET_M || state_d == S_RINGING))
      phase_d = 1'b1;
    else if (SEC_TICK)
      phase_d = ~phase_q;
  end

  // Output decode from the next-state values so outputs line up with STATE.
  always_comb begin
    fnd_en_d = 1'b0;
    d_h10_d  = BLANK;
    d_h1_d   = BLANK;
    d_m10_d  = BLANK;
    d_m1_d   = BLANK;
    buzzer_d = (state_d == S_RINGING);
    armed_d  = (state_d == S_ARMED) || (state_d == S_RINGING) || (state_d == S_SNOOZE);
    case (state_d)
      S_SET_H: begin
        fnd_en_d = 1'b1;
        d_m10_d  = a_m10_d;
        d_m1_d   = a_m1_d;
        if (phase_d) begin
          d_h10_d = a_h10_d;
          d_h1_d  = a_h1_d;
        end
      end
      S_SET_M: begin
        fnd_en_d = 1'b1;
        d_h10_d  = a_h10_d;
        d_h1_d   = a_h1_d;
        if (phase_d) begin
          d_m10_d = a_m10_d;
          d_m1_d  = a_m1_d;
        end
      end
      S_RINGING: begin
        fnd_en_d = 1'b1;
        if (phase_d) begin
          d_h10_d = a_h10_d;
          d_h1_d  = a_h1_d;
          d_m10_d = a_m10_d;
          d_m1_d  = a_m1_d;
        end
      end
      default: ;
    endcase
  end

  // State, data and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q    <= S_IDLE;
      a_h10_q    <= '0;
      a_h1_q     <= '0;
      a_m10_q    <= '0;
      a_m1_q     <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      phase_q    <= 1'b1;
      d_h10_q    <= BLANK;
      d_h1_q     <= BLANK;
      d_m10_q    <= BLANK;
      d_m1_q     <= BLANK;
      fnd_en_q   <= 1'b0;
      buzzer_q   <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_h10_q    <= a_h10_d;
      a_h1_q     <= a_h1_d;
      a_m10_q    <= a_m10_d;
      a_m1_q     <= a_m1_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      phase_q    <= phase_d;
      d_h10_q    <= d_h10_d;
      d_h1_q     <= d_h1_d;
      d_m10_q    <= d_m10_d;
      d_m1_q     <= d_m1_d;
      fnd_en_q   <= fnd_en_d;
      buzzer_q   <= buzzer_d;
      armed_q    <= armed_d;
    end
  end

  assign STATE  = state_q;
  assign A_H10  = a_h10_q;
  assign A_H1   = a_h1_q;
  assign A_M10  = a_m10_q;
  assign A_M1   = a_m1_q;
  assign D_H10  = d_h10_q;
  assign D_H1   = d_h1_q;
  assign D_M10  = d_m10_q;
  assign D_M1   = d_m1_q;
  assign FND_EN = fnd_en_q;
  assign BUZZER = buzzer_q;
  assign ARMED  = armed_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Testbench for alarm_ctrl: directed scenarios plus random stimulus, every
// cycle checked by a monitor against expectations queued by a reference model.
module tb_alarm_ctrl;

  localparam int RING_SEC   = 60;
  localparam int SNOOZE_SEC = 300;

  logic       CLK = 1'b0;
  logic       RESETN, SEC_TICK, BTN_MODE, BTN_UP, BTN_OK, T_SEC_ZERO;
  logic [3:0] T_H10, T_H1, T_M10, T_M1;
  logic [3:0] A_H10, A_H1, A_M10, A_M1;
  logic [3:0] D_H10, D_H1, D_M10, D_M1;
  logic       FND_EN, BUZZER, ARMED;
  logic [2:0] STATE;

  always #5 CLK = ~CLK;

  alarm_ctrl #(.RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC)) dut (
    .CLK(CLK), .RESETN(RESETN), .SEC_TICK(SEC_TICK),
    .BTN_MODE(BTN_MODE), .BTN_UP(BTN_UP), .BTN_OK(BTN_OK),
    .T_H10(T_H10), .T_H1(T_H1), .T_M10(T_M10), .T_M1(T_M1),
    .T_SEC_ZERO(T_SEC_ZERO),
    .A_H10(A_H10), .A_H1(A_H1), .A_M10(A_M10), .A_M1(A_M1),
    .D_H10(D_H10), .D_H1(D_H1), .D_M10(D_M10), .D_M1(D_M1),
    .FND_EN(FND_EN), .BUZZER(BUZZER), .ARMED(ARMED), .STATE(STATE)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] a;
    logic [15:0] d;
    logic        fnd;
    logic        buz;
    logic        arm;
  } obs_t;

  obs_t  exp_q[$];
  string lbl_q[$];
  int    n_checks = 0, n_pass = 0, n_push = 0, n_pop = 0;

  // Reference model state: alarm kept as plain hour/minute integers.
  int m_st, a_hr, a_mn, ring_cnt, snz_cnt;
  bit phase;

  function automatic logic [15:0] bcd4(input int hr, input int mn);
    return {4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10)};
  endfunction

  function automatic void model_update(input bit rstn, input bit tick, input bit mode,
                                       input bit up, input bit ok, input int t_hr,
                                       input int t_mn, input bit secz);
    int ns;
    bit mode_a, up_a, anyb;
    if (!rstn) begin
      m_st = 0; a_hr = 0; a_mn = 0; ring_cnt = 0; snz_cnt = 0; phase = 1'b1;
      return;
    end
    mode_a = mode && !ok;
    up_a   = up && !ok && !mode;
    anyb   = ok || mode || up;
    ns     = m_st;
    case (m_st)
      0: if (ok) ns = 3; else if (mode_a) ns = 1;
      1: if (ok) ns = 3; else if (mode_a) ns = 2; else if (up_a) a_hr = (a_hr + 1) % 24;
      2: if (ok) ns = 3; else if (mode_a) ns = 1; else if (up_a) a_mn = (a_mn + 1) % 60;
      3: begin
        if (ok) ns = 0;
        else if (mode_a) ns = 1;
        else if (!anyb && tick && secz && t_hr == a_hr && t_mn == a_mn) ns = 4;
      end
      4: begin
        if (ok) ns = 3;
        else if (up_a) begin ns = 5; snz_cnt = SNOOZE_SEC; end
        else if (tick) begin
          ring_cnt++;
          if (ring_cnt == RING_SEC) ns = 3;
        end
      end
      5: begin
        if (ok) ns = 3;
        else if (tick) begin
          snz_cnt--;
          if (snz_cnt == 0) ns = 4;
        end
      end
      default: ns = 0;
    endcase
    if (ns == 4 && m_st != 4) ring_cnt = 0;
    if (ns != m_st && (ns == 1 || ns == 2 || ns == 4)) phase = 1'b1;
    else if (tick) phase = !phase;
    m_st = ns;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    logic [15:0] a;
    a     = bcd4(a_hr, a_mn);
    o.st  = 3'(m_st);
    o.a   = a;
    o.fnd = (m_st == 1 || m_st == 2 || m_st == 4);
    o.buz = (m_st == 4);
    o.arm = (m_st == 3 || m_st == 4 || m_st == 5);
    o.d   = 16'hFFFF;
    if (m_st == 1) o.d = {phase ? a[15:8] : 8'hFF, a[7:0]};
    if (m_st == 2) o.d = {a[15:8], phase ? a[7:0] : 8'hFF};
    if (m_st == 4) o.d = phase ? a : 16'hFFFF;
    return o;
  endfunction

  // Drive one cycle of inputs and queue the response expected after the edge.
  task automatic step(input bit rstn, input bit tick, input bit mode, input bit up,
                      input bit ok, input int t_hr, input int t_mn, input bit secz,
                      input string lbl);
    logic [15:0] t;
    @(negedge CLK);
    t          = bcd4(t_hr, t_mn);
    RESETN     = rstn;
    SEC_TICK   = tick;
    BTN_MODE   = mode;
    BTN_UP     = up;
    BTN_OK     = ok;
    T_H10      = t[15:12];
    T_H1       = t[11:8];
    T_M10      = t[7:4];
    T_M1       = t[3:0];
    T_SEC_ZERO = secz;
    model_update(rstn, tick, mode, up, ok, t_hr, t_mn, secz);
    exp_q.push_back(model_obs());
    lbl_q.push_back(lbl);
    n_push++;
  endtask

  task automatic idle(input int n, input string lbl);
    repeat (n) step(1, 0, 0, 0, 0, 0, 0, 0, lbl);
  endtask

  // One SEC_TICK followed by a quiet cycle.
  task automatic tick2(input string lbl);
    step(1, 1, 0, 0, 0, 12, 34, 0, lbl);
    step(1, 0, 0, 0, 0, 12, 34, 0, lbl);
  endtask

  // Monitor: compare every presented output cycle against the queue head.
  obs_t  mon_exp, mon_got;
  string mon_lbl;
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_lbl = lbl_q.pop_front();
      mon_got = {STATE, A_H10, A_H1, A_M10, A_M1, D_H10, D_H1, D_M10, D_M1,
                 FND_EN, BUZZER, ARMED};
      n_pop++;
      n_checks++;
      if (mon_got === mon_exp) n_pass++;
      else $display("FAIL %s @%0t: got st=%0d a=%h d=%h fnd=%b buz=%b arm=%b, expected st=%0d a=%h d=%h fnd=%b buz=%b arm=%b",
                    mon_lbl, $time, mon_got.st, mon_got.a, mon_got.d, mon_got.fnd,
                    mon_got.buz, mon_got.arm, mon_exp.st, mon_exp.a, mon_exp.d,
                    mon_exp.fnd, mon_exp.buz, mon_exp.arm);
    end
  end

  initial begin
    RESETN = 1'b0; SEC_TICK = 1'b0; BTN_MODE = 1'b0; BTN_UP = 1'b0; BTN_OK = 1'b0;
    T_H10 = 4'd0; T_H1 = 4'd0; T_M10 = 4'd0; T_M1 = 4'd0; T_SEC_ZERO = 1'b0;

    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, "reset");
    idle(2, "post_reset");

    // Alarm entry: hours wrap 23->00, then 07; minutes wrap 59->00.
    step(1, 0, 1, 0, 0, 0, 0, 0, "to_set_h");
    repeat (23) step(1, 0, 0, 1, 0, 0, 0, 0, "hour_up");
    step(1, 0, 0, 1, 0, 0, 0, 0, "hour_wrap");
    repeat (7) step(1, 0, 0, 1, 0, 0, 0, 0, "hour_to_07");
    repeat (3) tick2("set_h_blink");
    step(1, 0, 1, 0, 0, 0, 0, 0, "to_set_m");
    repeat (59) step(1, 0, 0, 1, 0, 0, 0, 0, "min_up");
    step(1, 0, 0, 1, 0, 0, 0, 0, "min_wrap");
    repeat (3) tick2("set_m_blink");
    step(1, 0, 1, 1, 0, 0, 0, 0, "mode_beats_up");
    step(1, 0, 1, 0, 0, 0, 0, 0, "back_to_set_m");

    // Arm, match at 07:00, ring out the full duration.
    step(1, 0, 0, 0, 1, 0, 0, 0, "arm");
    step(1, 1, 0, 0, 0, 7, 0, 0, "no_match_secz0");
    step(1, 0, 0, 0, 0, 7, 0, 1, "no_match_notick");
    step(1, 1, 0, 0, 0, 7, 0, 1, "match");
    repeat (RING_SEC) tick2("ring_autostop");
    idle(2, "after_autostop");

    // Snooze cycle back into ringing, then OK from snooze.
    step(1, 1, 0, 0, 0, 7, 0, 1, "match2");
    repeat (4) tick2("ring2");
    step(1, 0, 1, 0, 0, 0, 0, 0, "ring_mode_ignored");
    step(1, 0, 0, 1, 0, 0, 0, 0, "snooze");
    repeat (SNOOZE_SEC) tick2("snooze_run");
    step(1, 0, 0, 1, 0, 0, 0, 0, "snooze_again");
    repeat (5) tick2("snooze2");
    step(1, 0, 1, 1, 0, 0, 0, 0, "snooze_btn_ignored");
    step(1, 0, 0, 0, 1, 0, 0, 0, "snooze_ok");

    // Button beats match; OK beats UP in ringing.
    step(1, 1, 0, 0, 1, 7, 0, 1, "match_with_ok");
    step(1, 0, 0, 0, 1, 0, 0, 0, "rearm");
    step(1, 1, 0, 1, 0, 7, 0, 1, "match_with_up");
    step(1, 1, 0, 0, 0, 7, 0, 1, "match3");
    step(1, 0, 0, 1, 1, 0, 0, 0, "ring_ok_up");

    // Reset in the middle of ringing.
    step(1, 1, 0, 0, 0, 7, 0, 1, "match4");
    repeat (3) tick2("ring4");
    step(0, 1, 1, 1, 1, 7, 0, 1, "reset_ring");
    idle(2, "after_reset_ring");

    // Random stimulus; T often equals the model's alarm to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      int hr, mn;
      if ($urandom_range(0, 1) == 1) begin hr = a_hr; mn = a_mn; end
      else begin hr = $urandom_range(0, 23); mn = $urandom_range(0, 59); end
      step($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 19) == 0, hr, mn, $urandom_range(0, 1) == 1, "random");
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    #2;
    n_checks++;
    if (exp_q.size() == 0 && n_pop == n_push) n_pass++;
    else $display("FAIL drain: popped %0d of %0d queued, required all", n_pop, n_push);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
